lcd_ctrl: RTL and testbench

- Image-display controller holding a 12-column x 9-row, 8-bit grayscale frame (108 pixels) in internal registers.
- Accepts one command at a time: load, zoom in, zoom fit, and four shift directions.
- After every command it streams a 4x4 pixel view (16 bytes) to the LCD driver.
- Sits between the host command interface and the LCD data bus.

---
 rtl/lcd_ctrl_if.sv | 20 ++
 rtl/lcd_ctrl.sv | 153 +++++++++++++++
 tb/tb_lcd_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// Command/pixel bus between the host, lcd_ctrl and the LCD driver.
// The host drives datain/cmd/cmd_valid; the controller drives dataout/output_valid/busy.
interface lcd_ctrl_if;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  modport master (
    output datain, cmd, cmd_valid,
    input  dataout, output_valid, busy
  );

  modport slave (
    input  datain, cmd, cmd_valid,
    output dataout, output_valid, busy
  );
endinterface

// File: rtl/lcd_ctrl.sv
// Grayscale frame store with zoom/fit/shift view selection.
// Every command ends with a 4x4 window streamed out, one byte per cycle.
module lcd_ctrl #(
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN   = 4
) (
  input  logic       clk,
  input  logic       reset,
  lcd_ctrl_if.slave  bus
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned OW   = $clog2(WIN * WIN);

  localparam logic [3:0] X0   = 4'(IMG_W / 2);
  localparam logic [3:0] Y0   = 4'(IMG_H / 2);
  localparam logic [3:0] XMIN = 4'(WIN / 2);
  localparam logic [3:0] XMAX = 4'(IMG_W - WIN / 2);
  localparam logic [3:0] YMIN = 4'(WIN / 2);
  localparam logic [3:0] YMAX = 4'(IMG_H - WIN / 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_OUT} state_t;
  typedef enum logic {M_FIT, M_ZOOM} mode_t;

  state_t          r_state, w_state;
  mode_t           r_mode,  w_mode;
  logic [3:0]      r_x,     w_x;
  logic [3:0]      r_y,     w_y;
  logic [2:0]      r_cmd,   w_cmd;
  logic [AW-1:0]   r_lcnt,  w_lcnt;
  logic [OW-1:0]   r_ocnt,  w_ocnt;
  logic [7:0]      r_dout,  w_dout;
  logic            r_ov,    w_ov;
  logic            r_busy,  w_busy;

  logic [7:0]      r_mem [NPIX];

  // FIT samples a sparse grid starting at (1,1); ZOOM is a dense window around the center.
  function automatic logic [AW-1:0] pix_addr(mode_t m, logic [3:0] x, logic [3:0] y,
                                              logic [OW-1:0] idx);
    int unsigned row;
    int unsigned col;
    if (m == M_FIT) begin
      row = 1 + (IMG_H / WIN) * (int'(idx) / WIN);
      col = 1 + (IMG_W / WIN) * (int'(idx) % WIN);
    end else begin
      row = int'(y) - WIN / 2 + int'(idx) / WIN;
      col = int'(x) - WIN / 2 + int'(idx) % WIN;
    end
    return AW'(row * IMG_W + col);
  endfunction

  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_x     = r_x;
    w_y     = r_y;
    w_cmd   = r_cmd;
    w_lcnt  = r_lcnt;
    w_ocnt  = r_ocnt;
    w_dout  = r_dout;
    w_ov    = r_ov;
    w_busy  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_busy  = 1'b1;
          w_cmd   = bus.cmd;
          w_lcnt  = '0;
          w_state = (bus.cmd == 3'd0) ? S_LOAD : S_PROC;
        end
      end
      S_LOAD: begin
        if (r_lcnt == AW'(NPIX - 1)) w_state = S_PROC;
        else                         w_lcnt  = r_lcnt + 1'b1;
      end
      S_PROC: begin
        case (r_cmd)
          3'd0, 3'd2: begin
            w_mode = M_FIT;
            w_x    = X0;
            w_y    = Y0;
          end
          3'd1: begin
            if (r_mode == M_FIT) begin
              w_x = X0;
              w_y = Y0;
            end
            w_mode = M_ZOOM;
          end
          3'd3: if (r_mode == M_ZOOM && r_x < XMAX) w_x = r_x + 4'd1;
          3'd4: if (r_mode == M_ZOOM && r_x > XMIN) w_x = r_x - 4'd1;
          3'd5: if (r_mode == M_ZOOM && r_y > YMIN) w_y = r_y - 4'd1;
          3'd6: if (r_mode == M_ZOOM && r_y < YMAX) w_y = r_y + 4'd1;
          default: ;
        endcase
        // First pixel uses the freshly updated view so output starts on the very next edge.
        w_dout  = r_mem[pix_addr(w_mode, w_x, w_y, '0)];
        w_ov    = 1'b1;
        w_ocnt  = '0;
        w_state = S_OUT;
      end
      S_OUT: begin
        if (r_ocnt == OW'(WIN * WIN - 1)) begin
          w_ov    = 1'b0;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_dout = r_mem[pix_addr(r_mode, r_x, r_y, r_ocnt + 1'b1)];
          w_ocnt = r_ocnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= M_FIT;
      r_x     <= X0;
      r_y     <= Y0;
      r_cmd   <= '0;
      r_lcnt  <= '0;
      r_ocnt  <= '0;
      r_dout  <= '0;
      r_ov    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_x     <= w_x;
      r_y     <= w_y;
      r_cmd   <= w_cmd;
      r_lcnt  <= w_lcnt;
      r_ocnt  <= w_ocnt;
      r_dout  <= w_dout;
      r_ov    <= w_ov;
      r_busy  <= w_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) r_mem[r_lcnt] <= bus.datain;
  end

  assign bus.dataout      = r_dout;
  assign bus.output_valid = r_ov;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Table-driven bench for lcd_ctrl: each entry is a command plus the view it must produce;
// a scoreboard queue holds the 16 expected bytes, popped by a monitor on output_valid.
module tb_lcd_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_if bus();

  lcd_ctrl #(.IMG_W(12), .IMG_H(9), .WIN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] cmd;
    bit         fit;
    int         x;
    int         y;
    bit         poke;
    bit         rst;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] img[108];
  int         fit_addr[16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  vec_t       tbl[$];
  bit         last_fit = 1'b1;
  int         last_x = 6;
  int         last_y = 4;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_view(input bit fit, input int x, input int y);
    int a;
    for (int k = 0; k < 16; k++) begin
      if (fit) a = fit_addr[k];
      else     a = (y - 2 + k / 4) * 12 + (x - 2 + k % 4);
      sb.push_back(img[a]);
    end
  endfunction

  always @(negedge clk) begin
    logic [7:0] e;
    if (reset && bus.output_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out: got dataout=%0h, expected no output", bus.dataout);
      end else begin
        e = sb.pop_front();
        chk("pixel", bus.dataout, e);
      end
    end
  end

  task automatic do_cmd(input logic [2:0] c, input bit poke);
    int lat;
    int len;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd3;
    chk("busy_accept", bus.busy, 1);
    if (c == 3'd0) begin
      for (int i = 0; i < 108; i++) begin
        bus.datain = img[i];
        @(negedge clk);
      end
      bus.datain = 8'hEE;
      chk("busy_load", bus.busy, 1);
      chk("ov_during_load", bus.output_valid, 0);
    end
    lat = 0;
    while (!bus.output_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("out_latency", lat, 1);
    len = 0;
    while (bus.output_valid && len < 40) begin
      if (poke && len == 3) begin
        bus.cmd       = 3'd3;
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      len++;
    end
    bus.cmd_valid = 1'b0;
    chk("out_len", len, 16);
    chk("busy_end", bus.busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic reset_mid_out();
    push_view(last_fit, last_x, last_y);
    @(negedge clk);
    bus.cmd       = 3'd7;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_ov", bus.output_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_ov", bus.output_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.dataout, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ov", bus.output_valid, 0);
  endtask

  initial begin
    bus.datain    = 8'h00;
    bus.cmd       = 3'd0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 108; i++) img[i] = 8'(i);

    //          cmd   fit  x   y  poke rst
    tbl.push_back('{3'd0, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd1, 0, 6, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 7, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 8, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 9, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 10, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 10, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 10, 4, 0, 0});
    tbl.push_back('{3'd3, 0, 10, 4, 0, 0});
    tbl.push_back('{3'd2, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd1, 0, 6, 4, 0, 0});
    tbl.push_back('{3'd5, 0, 6, 3, 0, 0});
    tbl.push_back('{3'd5, 0, 6, 2, 0, 0});
    tbl.push_back('{3'd5, 0, 6, 2, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 3, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 4, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 5, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 6, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 7, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 7, 0, 0});
    tbl.push_back('{3'd2, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd4, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd1, 0, 6, 4, 0, 0});
    tbl.push_back('{3'd4, 0, 5, 4, 1, 0});
    tbl.push_back('{3'd7, 0, 5, 4, 0, 0});
    tbl.push_back('{3'd4, 0, 4, 4, 0, 0});
    tbl.push_back('{3'd4, 0, 3, 4, 0, 0});
    tbl.push_back('{3'd4, 0, 2, 4, 0, 0});
    tbl.push_back('{3'd4, 0, 2, 4, 0, 0});
    tbl.push_back('{3'd0, 1, 6, 4, 0, 1});
    tbl.push_back('{3'd3, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd5, 1, 6, 4, 0, 0});
    tbl.push_back('{3'd1, 0, 6, 4, 0, 0});
    tbl.push_back('{3'd6, 0, 6, 5, 0, 0});
    tbl.push_back('{3'd3, 0, 7, 5, 0, 0});
    tbl.push_back('{3'd7, 0, 7, 5, 0, 0});

    repeat (3) @(negedge clk);
    chk("reset_dout", bus.dataout, 0);
    chk("reset_ov", bus.output_valid, 0);
    chk("reset_busy", bus.busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        reset_mid_out();
        for (int j = 0; j < 108; j++) img[j] = 8'((j * 37 + 11) & 255);
      end
      push_view(tbl[i].fit, tbl[i].x, tbl[i].y);
      do_cmd(tbl[i].cmd, tbl[i].poke);
      last_fit = tbl[i].fit;
      last_x   = tbl[i].x;
      last_y   = tbl[i].y;
    end

    repeat (4) @(negedge clk);
    chk("final_idle_ov", bus.output_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
